// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed seven-segment scan controller
// Steps one digit per t_1k edge, latches the value per frame, optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  t_1k,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  blank_lz,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

  logic                t_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       nidx;
  logic [VW-1:0]       val_q;
  logic [VW-1:0]       frame;
  logic [VW-1:0]       shifted;
  logic [3:0]          nib;
  logic                step;
  logic                blank;
  logic [N_DIGITS-1:0] an_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] d);
    case (d)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  // On the wrap to digit 0 the fresh value is decoded directly so the new frame starts coherent.
  always_comb begin
    step    = t_1k ^ t_q;
    nidx    = (idx == LAST) ? '0 : idx + IW'(1);
    frame   = (nidx == '0) ? value : val_q;
    shifted = frame >> {nidx, 2'b00};
    nib     = shifted[3:0];
    blank   = blank_lz && (nidx != '0) && (shifted == '0);
    for (int k = 0; k < N_DIGITS; k++) begin
      an_next[k] = (IW'(k) != nidx);
    end
  end

  always_ff @(posedge clk) begin
    t_q <= t_1k;
    if (rst) begin
      idx   <= LAST;
      val_q <= '0;
      an    <= '1;
      seg   <= 7'h7F;
    end else if (step) begin
      idx <= nidx;
      if (nidx == '0) begin
        val_q <= value;
      end
      if (blank) begin
        an  <= '1;
        seg <= 7'h7F;
      end else begin
        an  <= an_next;
        seg <= hex_decode(nib);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
// Behavioural digit/frame model compared every cycle, plus literal expectations.
module tb_display_scan_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          t_1k;
  logic [15:0]   value;
  logic          blank_lz;
  logic [N-1:0]  an;
  logic [6:0]    seg;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int         m_digit;
  logic [15:0] m_frame;
  logic       m_t;
  logic [N-1:0] exp_an;
  logic [6:0] exp_seg;

  display_scan_ctrl #(.N_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .t_1k(t_1k), .value(value),
    .blank_lz(blank_lz), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Model: a digit counter that wraps mod N and a frame value captured at each wrap.
  always @(posedge clk) begin
    if (rst) begin
      m_digit = N - 1;
      m_frame = '0;
      exp_an  = '1;
      exp_seg = 7'h7F;
    end else if (t_1k != m_t) begin
      m_digit = (m_digit + 1) % N;
      if (m_digit == 0) m_frame = value;
      if (blank_lz && m_digit > 0 && (m_frame >> (4 * m_digit)) == 0) begin
        exp_an  = '1;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(N'(1) << m_digit);
        exp_seg = hex_tab[4'(m_frame >> (4 * m_digit))];
      end
    end
    m_t = t_1k;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an", 32'(an), 32'(exp_an));
      check("model_seg", 32'(seg), 32'(exp_seg));
    end
  end

  task automatic step_chk(input logic [N-1:0] ea, input logic [6:0] es, input string name);
    t_1k = ~t_1k;
    @(negedge clk);
    check({name, "_an"}, 32'(an), 32'(ea));
    check({name, "_seg"}, 32'(seg), 32'(es));
    repeat (4) @(negedge clk);
  endtask

  task automatic step_only();
    t_1k = ~t_1k;
    repeat (3) @(negedge clk);
  endtask

  task automatic align_to(input int d);
    for (int i = 0; i < N && m_digit != d; i++) step_only();
    check("align", 32'(m_digit), 32'(d));
  endtask

  task automatic frame_chk(input logic [15:0] v, input logic [4*N-1:0] ea,
                           input logic [27:0] es, input string name);
    align_to(N - 1);
    value    = v;
    blank_lz = 1'b1;
    for (int k = 0; k < N; k++) step_chk(ea[4*k +: 4], es[7*k +: 7], name);
  endtask

  initial begin
    rst = 1'b1; t_1k = 1'b1; value = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_an", 32'(an), 32'h0000_000F);
    check("reset_seg", 32'(seg), 32'h0000_007F);
    check("reset_idx", 32'(m_digit), 32'd3);

    value = 16'h1A3F;
    step_chk(4'b1110, 7'h0E, "f1_d0");
    step_chk(4'b1101, 7'h30, "f1_d1");
    step_chk(4'b1011, 7'h08, "f1_d2");
    step_chk(4'b0111, 7'h79, "f1_d3");
    step_chk(4'b1110, 7'h0E, "f2_d0");
    step_chk(4'b1101, 7'h30, "f2_d1");
    value = 16'h0000;
    step_chk(4'b1011, 7'h08, "mid_d2");
    step_chk(4'b0111, 7'h79, "mid_d3");
    step_chk(4'b1110, 7'h40, "mid_d0");

    // Per-digit literals packed digit 0 in the low bits.
    frame_chk(16'h0005, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
              {7'h7F, 7'h7F, 7'h7F, 7'h12}, "blk5");
    frame_chk(16'h0000, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
              {7'h7F, 7'h7F, 7'h7F, 7'h40}, "blk0");
    frame_chk(16'h0500, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
              {7'h7F, 7'h12, 7'h40, 7'h40}, "blk500");

    blank_lz = 1'b0;
    value = 16'h1234;
    align_to(1);
    step_chk(4'b1011, 7'h24, "pre_rst_d2");
    rst = 1'b1;
    t_1k = ~t_1k;
    @(negedge clk);
    check("rst_edge_an", 32'(an), 32'h0000_000F);
    check("rst_edge_seg", 32'(seg), 32'h0000_007F);
    rst = 1'b0;
    value = 16'hBEE4;
    repeat (3) @(negedge clk);
    check("post_rst_an", 32'(an), 32'h0000_000F);
    step_chk(4'b1110, 7'h19, "post_rst_d0");

    // Back-to-back edges: one step per cycle.
    for (int i = 0; i < 12; i++) begin
      t_1k = ~t_1k;
      @(negedge clk);
    end
    check("rapid_digit", 32'(m_digit), 32'd0);
    check("rapid_an", 32'(an), 32'h0000_000E);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) t_1k = ~t_1k;
      if ($urandom_range(0, 15) == 0) value = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'hFFFF);
      if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
